// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with optional round-half-up quotient
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      request, sampled only while busy_o=0
//   dividend_i   dividend N
//   divisor_i    divisor D
//   busy_o       operation in progress (stays high through the valid_o cycle)
//   valid_o      one-cycle pulse, results updated this cycle
//   quotient_o   quotient Q, held until next valid_o
//   remainder_o  remainder R, held until next valid_o
//   div_zero_o   last completed operation had D=0, held
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;      // one spare bit so the shift keeps its MSB when D > 2^(WIDTH-1)
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic             ge;
  logic             round_up;

  always_comb begin
    r_shift  = {r[WIDTH-1:0], n[cnt]};
    r_sub    = r_shift - {1'b0, d};
    ge       = (r_shift >= {1'b0, d});
    // 2R >= D; Q is never all ones when this holds, so Q+1 cannot wrap
    round_up = (ROUND != 0) && ({r, 1'b0} >= {2'b00, d});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      n           <= '0;
      d           <= '0;
      q           <= '0;
      r           <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          // busy_o is still high in the cycle after FINISH, which blocks a start there
          if (start_i && !busy_o) begin
            n      <= dividend_i;
            d      <= divisor_i;
            r      <= '0;
            q      <= '0;
            cnt    <= CW'(WIDTH - 1);
            dz     <= (divisor_i == '0);
            busy_o <= 1'b1;
            state  <= (divisor_i == '0) ? FINISH : CALC;
          end else begin
            busy_o <= 1'b0;
          end
        end
        CALC: begin
          r      <= ge ? r_sub : r_shift;
          q[cnt] <= ge;
          if (cnt == '0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          valid_o    <= 1'b1;
          div_zero_o <= dz;
          state      <= IDLE;
          if (dz) begin
            quotient_o  <= '1;
            remainder_o <= n;
          end else begin
            quotient_o  <= q + {{(WIDTH-1){1'b0}}, round_up};
            remainder_o <= r[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (16-bit truncating, 16-bit rounding, 8-bit)
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st  [3];
  logic [31:0] dvd [3];
  logic [31:0] dvs [3];
  logic        bsy [3];
  logic        vld [3];
  logic        dzo [3];
  logic [31:0] quo [3];
  logic [31:0] rem [3];

  logic [15:0] q0, r0, q1, r1;
  logic [7:0]  q2, r2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(16), .ROUND(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(st[0]), .dividend_i(dvd[0][15:0]), .divisor_i(dvs[0][15:0]),
    .busy_o(bsy[0]), .valid_o(vld[0]), .quotient_o(q0), .remainder_o(r0), .div_zero_o(dzo[0]));
  seq_divider #(.WIDTH(16), .ROUND(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st[1]), .dividend_i(dvd[1][15:0]), .divisor_i(dvs[1][15:0]),
    .busy_o(bsy[1]), .valid_o(vld[1]), .quotient_o(q1), .remainder_o(r1), .div_zero_o(dzo[1]));
  seq_divider #(.WIDTH(8), .ROUND(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(st[2]), .dividend_i(dvd[2][7:0]), .divisor_i(dvs[2][7:0]),
    .busy_o(bsy[2]), .valid_o(vld[2]), .quotient_o(q2), .remainder_o(r2), .div_zero_o(dzo[2]));

  always_comb begin
    quo[0] = {16'd0, q0};
    rem[0] = {16'd0, r0};
    quo[1] = {16'd0, q1};
    rem[1] = {16'd0, r1};
    quo[2] = {24'd0, q2};
    rem[2] = {24'd0, r2};
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: results from plain arithmetic, timing from the
  // cycle counts the interface promises (WIDTH+1 normal, 1 for D=0).
  int     wd [3] = '{16, 16, 8};
  int     rd [3] = '{0, 1, 0};
  int     mcnt [3];
  bit     mb [3], ev [3], edz [3], pdz [3];
  longint eq [3], er [3], pq [3], pr [3];
  bit     seen = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        longint msk, n, d;
        msk = (64'sd1 <<< wd[i]) - 1;
        n = longint'(dvd[i]) & msk;
        d = longint'(dvs[i]) & msk;
        if (rst) begin
          mcnt[i] = 0; mb[i] = 0; ev[i] = 0; eq[i] = 0; er[i] = 0; edz[i] = 0;
        end else begin
          ev[i] = 0;
          if (mcnt[i] > 0) begin
            mcnt[i]--;
            if (mcnt[i] == 0) begin
              ev[i] = 1; eq[i] = pq[i]; er[i] = pr[i]; edz[i] = pdz[i];
            end
          end else if (mb[i]) begin
            mb[i] = 0;
          end else if (st[i] === 1'b1) begin
            mb[i] = 1;
            if (d == 0) begin
              pq[i] = msk; pr[i] = n; pdz[i] = 1; mcnt[i] = 1;
            end else begin
              pq[i] = n / d; pr[i] = n % d; pdz[i] = 0; mcnt[i] = wd[i] + 1;
              if (rd[i] != 0 && 2 * pr[i] >= d) pq[i]++;
            end
          end
        end
      end
      if (rst) seen = 1'b1;
      #1;
      if (seen) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("valid[%0d]", i), 64'(vld[i]), 64'(ev[i]));
          check($sformatf("busy[%0d]", i), 64'(bsy[i]), 64'(mb[i]));
          check($sformatf("quotient[%0d]", i), 64'(quo[i]), eq[i]);
          check($sformatf("remainder[%0d]", i), 64'(rem[i]), er[i]);
          check($sformatf("div_zero[%0d]", i), 64'(dzo[i]), 64'(edz[i]));
        end
      end
    end
  end

  task automatic run(int i, longint n, longint d, longint xq, longint xr, bit xdz, int xlat, int poke);
    int lat;
    @(negedge clk);
    st[i] = 1'b1; dvd[i] = 32'(n); dvs[i] = 32'(d);
    @(posedge clk); #2;
    st[i] = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #2;
      lat++;
      if (vld[i]) break;
      if (poke > 0 && lat == poke) begin
        st[i] = 1'b1; dvd[i] = 9; dvs[i] = 9;
      end else if (poke > 0 && lat == poke + 1) begin
        st[i] = 1'b0; dvd[i] = 7777; dvs[i] = 1;
      end
    end
    check($sformatf("lat[%0d] %0d/%0d", i, n, d), 64'(lat), 64'(xlat));
    check($sformatf("q[%0d] %0d/%0d", i, n, d), 64'(quo[i]), 64'(xq));
    check($sformatf("r[%0d] %0d/%0d", i, n, d), 64'(rem[i]), 64'(xr));
    check($sformatf("dz[%0d] %0d/%0d", i, n, d), 64'(dzo[i]), 64'(xdz));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; dvd[i] = '0; dvs[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("reset busy", 64'(bsy[0]), 64'd0);
    check("reset valid", 64'(vld[0]), 64'd0);
    check("reset quotient", 64'(quo[0]), 64'd0);
    check("reset remainder", 64'(rem[0]), 64'd0);
    check("reset div_zero", 64'(dzo[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 100, 7, 14, 2, 0, 17, 0);
    run(0, 1234, 0, 16'hFFFF, 1234, 1, 1, 0);
    run(0, 40, 8, 5, 0, 0, 17, 0);
    run(0, 500, 3, 166, 2, 0, 17, 5);

    run(1, 10, 4, 3, 2, 0, 17, 0);
    run(1, 9, 4, 2, 1, 0, 17, 0);
    run(1, 65535, 1, 65535, 0, 0, 17, 0);

    run(2, 255, 128, 1, 127, 0, 9, 0);
    run(2, 5, 200, 0, 5, 0, 9, 0);

    // reset abandons an operation in progress
    @(negedge clk);
    st[0] = 1'b1; dvd[0] = 1000; dvs[0] = 10;
    @(posedge clk); #2;
    st[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("midreset valid", 64'(vld[0]), 64'd0);
    check("midreset busy", 64'(bsy[0]), 64'd0);
    check("midreset quotient", 64'(quo[0]), 64'd0);
    check("midreset remainder", 64'(rem[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    run(0, 1000, 10, 100, 0, 0, 17, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
